read_cycle: RTL and testbench
=============================

READ_CYCLE -- requirements
Module: read_cycle

Interface
REQ-001 SHALL have parameter DW, default 8, memory data width in bits.
REQ-002 SHALL have parameter AW, default 4, address width in bits.
REQ-003 SHALL have parameter ACCESS_CYCLES, default 3 (range 1..15), clocks that nOE is held low before capture.
REQ-004 SHALL have parameter WORDS, default 16, words per burst.
REQ-005 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-007 SHALL have port read, input, 1, burst-read request level.
REQ-008 SHALL have port write, input, 1, write-cycle-active level; inhibits reads.
REQ-009 SHALL have port mem_data, input, DW, SRAM data bus as seen by the controller.
REQ-010 SHALL have port nCS, output, 1, SRAM chip select, active-low.
REQ-011 SHALL have port nOE, output, 1, SRAM output enable, active-low.
REQ-012 SHALL have port DE, output, 1, controller data-bus drive enable; always 0 in this block.
REQ-013 SHALL have port latch, output, 1, one-cycle pulse when rd_data is updated.
REQ-014 SHALL have port count, output, 1, one-cycle pulse when addr advances.
REQ-015 SHALL have port reading, output, 1, high whenever the FSM is outside IDLE and DONE.
REQ-016 SHALL have port addr, output, AW, current SRAM address.
REQ-017 SHALL have port rd_data, output, DW, last captured word.

Function
REQ-018 FSM states SHALL be IDLE, SETUP, STROBE, CAPTURE, RELEASE, DONE.
REQ-019 IDLE->SETUP SHALL occur when read=1 and write=0; otherwise IDLE holds.
REQ-020 SETUP SHALL last 1 cycle: nCS=0, nOE=1.
REQ-021 STROBE SHALL last exactly ACCESS_CYCLES cycles: nCS=0, nOE=0.
REQ-022 CAPTURE SHALL last 1 cycle: nCS=0, nOE=0, latch=1, rd_data<=mem_data at the cycle's closing edge.
REQ-023 RELEASE SHALL last 1 cycle: nCS=1, nOE=1, count=1, addr<=addr+1 modulo 2^AW, word counter +1.
REQ-024 One word SHALL therefore take ACCESS_CYCLES+3 cycles (6 at default).
REQ-025 After RELEASE: if WORDS words completed -> DONE; else if read=1 and write=0 -> SETUP; else -> IDLE.
REQ-026 DONE SHALL hold with nCS=1, nOE=1 until read=0, then -> IDLE and clear the word counter; addr is not cleared.
REQ-027 read falling or write rising mid-word SHALL NOT abort the word; the current word completes through RELEASE, then REQ-025 applies.
REQ-028 addr SHALL wrap from 2^AW-1 to 0 without a stall.
REQ-029 nCS and nOE SHALL never be 0 while write=1 at the start of SETUP; read and write both 1 in IDLE -> stay IDLE.
REQ-030 latch and count SHALL never be high in the same cycle.

Reset
REQ-031 reset=0 SHALL immediately force: state IDLE, nCS=1, nOE=1, DE=0, latch=0, count=0, reading=0, addr=0, rd_data=0, word counter 0, checksum 0.
REQ-032 Reset mid-STROBE SHALL release nCS/nOE asynchronously; no latch or count pulse follows.

Configuration
REQ-033 Macro READ_CYCLE_CHECKSUM_EN SHALL, when defined, add output chk (DW bits) = XOR of all words captured since the last IDLE->SETUP from IDLE/DONE, updated with latch.
REQ-034 Without READ_CYCLE_CHECKSUM_EN, chk and its register SHALL be absent; all other behaviour identical.

Structure
REQ-035 A shared package SHALL hold the state encoding type and default DW, AW, ACCESS_CYCLES, WORDS constants, shared with write_cycle.
REQ-036 One sub-module access_timer SHALL implement the ACCESS_CYCLES down-counter (load, tick, expired).

Verification
REQ-037 Reset: reset=0 during STROBE -> nCS=1, nOE=1, addr=0, rd_data=0 the same cycle, no latch pulse.
REQ-038 Single word: read=1 one cycle then 0, mem_data=8'hA5 -> nOE low 4 cycles (STROBE+CAPTURE), latch at cycle 5, rd_data=8'hA5, count at cycle 6, addr=1, IDLE.
REQ-039 Full burst: read held 1, mem_data=addr -> 16 latch pulses 6 cycles apart, addr wraps 15->0, DONE, reading=0; read=0 -> IDLE.
REQ-040 Write inhibit: read=1, write=1 from reset -> nCS stays 1 for 50 cycles; write=0 -> SETUP next edge.
REQ-041 Mid-word abort: read drops in STROBE -> word completes, one latch, one count, then IDLE.
REQ-042 With READ_CYCLE_CHECKSUM_EN: burst of 8'h01,8'h02,8'h04,... first 4 words then read=0 -> chk=8'h0F.

Source files
------------

// File: rtl/read_cycle_pkg.sv
// rtl/read_cycle_pkg.sv - shared SRAM cycle state encoding and default geometry
package read_cycle_pkg;

    localparam int DEF_DW            = 8;
    localparam int DEF_AW            = 4;
    localparam int DEF_ACCESS_CYCLES = 3;
    localparam int DEF_WORDS         = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        CAPTURE,
        RELEASE,
        DONE
    } state_t;

endpackage

// File: rtl/read_cycle_access_timer.sv
// rtl/read_cycle_access_timer.sv - access_timer: nOE strobe length down-counter
module access_timer
    import read_cycle_pkg::*;
#(
    parameter int CYCLES = DEF_ACCESS_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic tick,
    output logic expired
);

    logic [3:0] remaining;

    // Loaded with CYCLES-1 so that expiry is seen on the last strobe cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= 4'(CYCLES - 1);
        end else if (tick && (remaining != '0)) begin
            remaining <= remaining - 4'd1;
        end
    end

    assign expired = (remaining == '0);

endmodule

// File: rtl/read_cycle.sv
// rtl/read_cycle.sv - SRAM burst read cycle controller (optional chk output under READ_CYCLE_CHECKSUM_EN)
module read_cycle
    import read_cycle_pkg::*;
#(
    parameter int DW            = DEF_DW,
    parameter int AW            = DEF_AW,
    parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES,
    parameter int WORDS         = DEF_WORDS
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          read,
    input  logic          write,
    input  logic [DW-1:0] mem_data,
    output logic          nCS,
    output logic          nOE,
    output logic          DE,
    output logic          latch,
    output logic          count,
    output logic          reading,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] rd_data
`ifdef READ_CYCLE_CHECKSUM_EN
    ,
    output logic [DW-1:0] chk
`endif
);

    localparam int WCW = $clog2(WORDS + 1);

    state_t         state;
    state_t         state_next;
    logic [WCW-1:0] word_cnt;
    logic           last_word;
    logic           timer_load;
    logic           timer_tick;
    logic           timer_expired;

    access_timer #(
        .CYCLES (ACCESS_CYCLES)
    ) u_access_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (timer_load),
        .tick    (timer_tick),
        .expired (timer_expired)
    );

    assign last_word = (word_cnt == WCW'(WORDS - 1));
    assign DE        = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bus strobes decode straight from state so reset releases them asynchronously.
    always_comb begin
        state_next = state;
        nCS        = 1'b1;
        nOE        = 1'b1;
        latch      = 1'b0;
        count      = 1'b0;
        reading    = 1'b0;
        timer_load = 1'b0;
        timer_tick = 1'b0;
        case (state)
            IDLE: begin
                if (read && !write) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                nCS        = 1'b0;
                reading    = 1'b1;
                timer_load = 1'b1;
                state_next = STROBE;
            end
            STROBE: begin
                nCS        = 1'b0;
                nOE        = 1'b0;
                reading    = 1'b1;
                timer_tick = 1'b1;
                if (timer_expired) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                nCS        = 1'b0;
                nOE        = 1'b0;
                latch      = 1'b1;
                reading    = 1'b1;
                state_next = RELEASE;
            end
            RELEASE: begin
                count   = 1'b1;
                reading = 1'b1;
                if (last_word) begin
                    state_next = DONE;
                end else if (read && !write) begin
                    state_next = SETUP;
                end else begin
                    state_next = IDLE;
                end
            end
            DONE: begin
                if (!read) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr     <= '0;
            rd_data  <= '0;
            word_cnt <= '0;
        end else begin
            if (latch) begin
                rd_data <= mem_data;
            end
            if (count) begin
                addr     <= addr + 1'b1;
                word_cnt <= word_cnt + 1'b1;
            end else if ((state == DONE) && !read) begin
                word_cnt <= '0;
            end
        end
    end

`ifdef READ_CYCLE_CHECKSUM_EN
    // Restarts only when a fresh burst leaves IDLE, not on back-to-back words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chk <= '0;
        end else if ((state == IDLE) && (state_next == SETUP)) begin
            chk <= '0;
        end else if (latch) begin
            chk <= chk ^ mem_data;
        end
    end
`endif

endmodule

// File: tb/tb_read_cycle.sv
// tb/tb_read_cycle.sv - self-checking bench for read_cycle (chk checks under READ_CYCLE_CHECKSUM_EN)
module tb_read_cycle;

    localparam int DW       = 8;
    localparam int AW       = 4;
    localparam int AC       = 3;
    localparam int WORDS    = 16;
    localparam int WORD_CYC = AC + 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [DW-1:0] mem_data;
    logic          nCS, nOE, DE, latch, count, reading;
    logic [AW-1:0] addr;
    logic [DW-1:0] rd_data;
`ifdef READ_CYCLE_CHECKSUM_EN
    logic [DW-1:0] chk;
`endif

    logic          use_addr = 1'b0;
    logic          onehot = 1'b0;
    logic [DW-1:0] mem_const = '0;
    logic [DW-1:0] key = '0;

    int checks = 0;
    int failures = 0;

    // SRAM stand-in: constant word, address-derived word, or one-hot by address.
    assign mem_data = onehot ? (DW'(1) << addr) : (use_addr ? (DW'(addr) ^ key) : mem_const);

    read_cycle #(
        .DW(DW), .AW(AW), .ACCESS_CYCLES(AC), .WORDS(WORDS)
    ) dut (
        .clk(clk), .reset(reset), .read(read), .write(write), .mem_data(mem_data),
        .nCS(nCS), .nOE(nOE), .DE(DE), .latch(latch), .count(count), .reading(reading),
        .addr(addr), .rd_data(rd_data)
`ifdef READ_CYCLE_CHECKSUM_EN
        , .chk(chk)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; read = 1'b0; write = 1'b0;
        use_addr = 1'b0; onehot = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        int pulses;
        #1;
        checks++; if (nCS !== 1'b1 || nOE !== 1'b1 || DE !== 1'b0) begin failures++; $display("FAIL reset_strobes: nCS=%b nOE=%b DE=%b expected 1 1 0", nCS, nOE, DE); end
        checks++; if (latch !== 1'b0 || count !== 1'b0 || reading !== 1'b0) begin failures++; $display("FAIL reset_pulses: latch=%b count=%b reading=%b expected 0 0 0", latch, count, reading); end
        checks++; if (addr !== '0 || rd_data !== '0) begin failures++; $display("FAIL reset_regs: addr=%0h rd_data=%0h expected 0 0", addr, rd_data); end
        do_reset();
        mem_const = 8'h5A;
        read = 1'b1; tick(); read = 1'b0;
        repeat (WORD_CYC) tick();
        read = 1'b1; tick(); tick();
        #2 reset = 1'b0;
        #1;
        checks++; if (nCS !== 1'b1 || nOE !== 1'b1 || addr !== '0 || rd_data !== '0 || reading !== 1'b0) begin failures++; $display("FAIL reset_mid_strobe: nCS=%b nOE=%b addr=%0h rd_data=%0h reading=%b expected 1 1 0 0 0", nCS, nOE, addr, rd_data, reading); end
        pulses = 0;
        read = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (latch || count) pulses++;
            if (c == 4) reset = 1'b1;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL reset_no_pulse: pulses=%0d expected 0", pulses); end
    endtask

    task automatic test_single_word();
        int noe_low, latch_at, count_at;
        logic [DW-1:0] rd6;
        logic [AW-1:0] addr7;
        logic reading7, setup_ok;
        do_reset();
        mem_const = 8'hA5;
        noe_low = 0; latch_at = -1; count_at = -1; rd6 = '0; addr7 = '0; reading7 = 1'b1; setup_ok = 1'b0;
        read = 1'b1; tick(); read = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) setup_ok = (nCS === 1'b0) && (nOE === 1'b1);
            if (nOE === 1'b0) noe_low++;
            if (latch === 1'b1) latch_at = c;
            if (count === 1'b1) count_at = c;
            if (c == AC + 3) rd6 = rd_data;
            if (c == AC + 4) begin addr7 = addr; reading7 = reading; end
        end
        checks++; if (setup_ok !== 1'b1) begin failures++; $display("FAIL single_setup: setup strobes wrong, got %b expected 1", setup_ok); end
        checks++; if (noe_low !== AC + 1) begin failures++; $display("FAIL single_noe_len: got %0d expected %0d", noe_low, AC + 1); end
        checks++; if (latch_at !== AC + 2) begin failures++; $display("FAIL single_latch_cycle: got %0d expected %0d", latch_at, AC + 2); end
        checks++; if (count_at !== AC + 3) begin failures++; $display("FAIL single_count_cycle: got %0d expected %0d", count_at, AC + 3); end
        checks++; if (rd6 !== 8'hA5) begin failures++; $display("FAIL single_rd_data: got %0h expected a5", rd6); end
        checks++; if (addr7 !== AW'(1) || reading7 !== 1'b0) begin failures++; $display("FAIL single_end: addr=%0h reading=%b expected 1 0", addr7, reading7); end
    endtask

    task automatic test_burst();
        int n_latch, last_latch, cyc, gap_err, data_err, both_err, model_addr;
        do_reset();
        use_addr = 1'b1; key = DW'($urandom);
        n_latch = 0; last_latch = -1; cyc = 0; gap_err = 0; data_err = 0; both_err = 0; model_addr = 0;
        read = 1'b1;
        for (int c = 0; c < WORDS * WORD_CYC + 12; c++) begin
            @(negedge clk);
            cyc++;
            if (latch && count) both_err++;
            if (latch === 1'b1) begin
                if (last_latch >= 0 && cyc - last_latch != WORD_CYC) gap_err++;
                last_latch = cyc;
                n_latch++;
            end
            if (count === 1'b1) begin
                if (rd_data !== (DW'(model_addr) ^ key)) data_err++;
                model_addr = (model_addr + 1) % (1 << AW);
            end
        end
        checks++; if (n_latch !== WORDS) begin failures++; $display("FAIL burst_words: got %0d expected %0d", n_latch, WORDS); end
        checks++; if (gap_err !== 0) begin failures++; $display("FAIL burst_spacing: bad gaps=%0d expected 0", gap_err); end
        checks++; if (data_err !== 0) begin failures++; $display("FAIL burst_data: bad words=%0d expected 0", data_err); end
        checks++; if (both_err !== 0) begin failures++; $display("FAIL burst_latch_count_overlap: got %0d expected 0", both_err); end
        checks++; if (addr !== '0 || reading !== 1'b0 || nCS !== 1'b1) begin failures++; $display("FAIL burst_done: addr=%0h reading=%b nCS=%b expected 0 0 1", addr, reading, nCS); end
        @(posedge clk); #1 read = 1'b0;
        @(posedge clk); #1 read = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++; if (nCS !== 1'b0 || reading !== 1'b1) begin failures++; $display("FAIL burst_restart: nCS=%b reading=%b expected 0 1", nCS, reading); end
        read = 1'b0;
        repeat (WORD_CYC + 2) tick();
    endtask

    task automatic test_write_inhibit();
        int viol;
        do_reset();
        viol = 0;
        read = 1'b1; write = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (nCS !== 1'b1 || reading !== 1'b0) viol++;
        end
        checks++; if (viol !== 0) begin failures++; $display("FAIL write_inhibit: active cycles=%0d expected 0", viol); end
        @(posedge clk); #1 write = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++; if (nCS !== 1'b0 || nOE !== 1'b1) begin failures++; $display("FAIL write_release_setup: nCS=%b nOE=%b expected 0 1", nCS, nOE); end
        read = 1'b0;
        repeat (WORD_CYC + 2) tick();
    endtask

    task automatic test_mid_word_abort();
        int n_latch, n_count;
        do_reset();
        mem_const = DW'($urandom);
        n_latch = 0; n_count = 0;
        read = 1'b1; tick(); tick();
        read = 1'b0; write = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (latch === 1'b1) n_latch++;
            if (count === 1'b1) n_count++;
        end
        checks++; if (n_latch !== 1 || n_count !== 1) begin failures++; $display("FAIL abort_pulses: latch=%0d count=%0d expected 1 1", n_latch, n_count); end
        checks++; if (reading !== 1'b0 || addr !== AW'(1) || rd_data !== mem_const) begin failures++; $display("FAIL abort_end: reading=%b addr=%0h rd_data=%0h expected 0 1 %0h", reading, addr, rd_data, mem_const); end
        write = 1'b0;
    endtask

    task automatic test_random();
        int model_addr, data_err, addr_err, both_err, start_err, words;
        logic s_read, s_write, prev_ncs;
        do_reset();
        use_addr = 1'b1; key = DW'($urandom);
        model_addr = 0; data_err = 0; addr_err = 0; both_err = 0; start_err = 0; words = 0;
        prev_ncs = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            s_read = read; s_write = write;
            #1;
            read  = ($urandom_range(0, 3) != 0);
            write = ($urandom_range(0, 5) == 0);
            @(negedge clk);
            if (prev_ncs && !nCS && !(s_read && !s_write)) start_err++;
            if (addr !== AW'(model_addr)) addr_err++;
            if (latch && count) both_err++;
            if (count === 1'b1) begin
                if (rd_data !== (DW'(model_addr) ^ key)) data_err++;
                model_addr = (model_addr + 1) % (1 << AW);
                words++;
            end
            prev_ncs = nCS;
        end
        checks++; if (start_err !== 0) begin failures++; $display("FAIL rand_start_rule: bad starts=%0d expected 0", start_err); end
        checks++; if (addr_err !== 0) begin failures++; $display("FAIL rand_addr: bad cycles=%0d expected 0", addr_err); end
        checks++; if (data_err !== 0) begin failures++; $display("FAIL rand_data: bad words=%0d of %0d expected 0", data_err, words); end
        checks++; if (both_err !== 0) begin failures++; $display("FAIL rand_overlap: got %0d expected 0", both_err); end
        read = 1'b0; write = 1'b0;
        repeat (WORD_CYC + 2) tick();
    endtask

`ifdef READ_CYCLE_CHECKSUM_EN
    task automatic test_checksum();
        int n_latch;
        do_reset();
        onehot = 1'b1;
        n_latch = 0;
        read = 1'b1;
        for (int c = 0; c < 4 * WORD_CYC + 10; c++) begin
            @(negedge clk);
            if (latch === 1'b1) begin
                n_latch++;
                if (n_latch == 4) read = 1'b0;
            end
        end
        checks++; if (chk !== 8'h0F || n_latch !== 4) begin failures++; $display("FAIL checksum: chk=%0h words=%0d expected 0f 4", chk, n_latch); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_burst();
        test_write_inhibit();
        test_mid_word_abort();
        test_random();
`ifdef READ_CYCLE_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
